// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character-LCD controllers: FSM states,
// default bus timing and command/address constants.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ENHI,
        RECOV,
        DONE
    } state_e;

    // Clock-cycle delays at 50 MHz.
    localparam logic [4:0]  AS_DLY    = 5'h4;
    localparam logic [4:0]  EN_DLY    = 5'h1f;
    localparam logic [11:0] WRITE_DLY = 12'd2000;
    localparam logic [16:0] CLEAR_DLY = 17'd82000;
    localparam logic [21:0] BOOT_DLY  = 22'd2500000;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0c;
    localparam logic [7:0] CMD_FUNC_SET  = 8'h38;
    localparam logic [7:0] CMD_SET_CGRAM = 8'h40;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
    localparam logic [6:0] ADDR_LINE1    = 7'h00;
    localparam logic [6:0] ADDR_LINE2    = 7'h40;

endpackage

// File: rtl/lcd_bus_sync.sv
// Two-flop synchronizer for the 8-bit LCD data bus, which is driven by the
// panel asynchronously to the system clock.
module lcd_bus_sync (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_d,
    output logic [7:0] o_q
);

    logic [7:0] meta_q;
    logic [7:0] sync_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/lcd_reader.sv
// HD44780 read-cycle controller: status reads (busy flag + address counter),
// data reads, and an optional busy-flag poll loop with timeout.
module lcd_reader #(
    parameter logic [4:0]  AS_DLY   = lcd_pkg::AS_DLY,
    parameter logic [4:0]  EN_DLY   = lcd_pkg::EN_DLY,
    parameter logic [5:0]  RCV_DLY  = 6'h28,
    parameter logic [20:0] POLL_MAX = 21'h13880
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_rs,
    input  logic       i_poll,
    output logic       o_busy,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_busy_flag,
    output logic [6:0] o_addr_cnt,
    output logic       o_timeout,
    input  logic [7:0] LCD_DATA_IN,
    output logic       LCD_DATA_OE,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN
);

    import lcd_pkg::*;

    // The bus is sampled through two sync flops, so EN must stay high longer.
    if (EN_DLY < 5'd3) begin : g_en_dly_chk
        $error("lcd_reader: EN_DLY must be at least 3");
    end

    state_e      state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [20:0] polls_q, polls_d;
    logic        rs_q, rs_d;
    logic        poll_mode_q, poll_mode_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic [7:0]  data_q, data_d;
    logic        bf_q, bf_d;
    logic [6:0]  ac_q, ac_d;
    logic        timeout_q, timeout_d;
    logic        lcd_rs_q, lcd_rs_d;
    logic        lcd_rw_q, lcd_rw_d;
    logic        lcd_en_q, lcd_en_d;
    logic [7:0]  bus_sync;

    lcd_bus_sync u_bus_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (LCD_DATA_IN),
        .o_q   (bus_sync)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        count_d     = count_q;
        polls_d     = polls_q;
        rs_d        = rs_q;
        poll_mode_d = poll_mode_q;
        busy_d      = busy_q;
        valid_d     = 1'b0;
        data_d      = data_q;
        bf_d        = bf_q;
        ac_d        = ac_q;
        timeout_d   = timeout_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_rw_d    = lcd_rw_q;
        lcd_en_d    = lcd_en_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    rs_d        = i_rs;
                    poll_mode_d = i_poll & ~i_rs;
                    busy_d      = 1'b1;
                    lcd_rw_d    = 1'b1;
                    lcd_rs_d    = i_rs;
                    count_d     = {1'b0, AS_DLY};
                    polls_d     = '0;
                    timeout_d   = 1'b0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                if (count_q == '0) begin
                    lcd_en_d = 1'b1;
                    count_d  = {1'b0, EN_DLY};
                    state_d  = ENHI;
                end else begin
                    count_d = count_q - 6'd1;
                end
            end
            ENHI: begin
                // Sample on the same edge that drops EN, while the panel still drives the bus.
                if (count_q == '0) begin
                    data_d = bus_sync;
                    if (!rs_q) begin
                        bf_d = bus_sync[7];
                        ac_d = bus_sync[6:0];
                    end
                    lcd_en_d = 1'b0;
                    count_d  = RCV_DLY;
                    state_d  = RECOV;
                end else begin
                    count_d = count_q - 6'd1;
                end
            end
            RECOV: begin
                if (count_q != '0) begin
                    count_d = count_q - 6'd1;
                end else if (poll_mode_q && data_q[7] && (polls_q < POLL_MAX - 21'd1)) begin
                    polls_d = polls_q + 21'd1;
                    count_d = {1'b0, AS_DLY};
                    state_d = SETUP;
                end else begin
                    valid_d   = 1'b1;
                    timeout_d = poll_mode_q & data_q[7];
                    state_d   = DONE;
                end
            end
            DONE: begin
                lcd_rw_d = 1'b0;
                lcd_rs_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            polls_q     <= '0;
            rs_q        <= 1'b0;
            poll_mode_q <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            bf_q        <= 1'b1;
            ac_q        <= '0;
            timeout_q   <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_rw_q    <= 1'b0;
            lcd_en_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop updates from the same pre-edge values.
            state_q     <= state_d;
            count_q     <= count_d;
            polls_q     <= polls_d;
            rs_q        <= rs_d;
            poll_mode_q <= poll_mode_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            bf_q        <= bf_d;
            ac_q        <= ac_d;
            timeout_q   <= timeout_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_rw_q    <= lcd_rw_d;
            lcd_en_q    <= lcd_en_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_valid     = valid_q;
    assign o_data      = data_q;
    assign o_busy_flag = bf_q;
    assign o_addr_cnt  = ac_q;
    assign o_timeout   = timeout_q;
    assign LCD_DATA_OE = 1'b0;
    assign LCD_RS      = lcd_rs_q;
    assign LCD_RW      = lcd_rw_q;
    assign LCD_EN      = lcd_en_q;

endmodule

// File: tb/tb_lcd_reader.sv
// Scoreboard bench for lcd_reader: a bus model answers each EN pulse from a
// queue, expected results are queued at i_start and compared at o_valid.
module tb_lcd_reader;

    localparam int AS_CYC      = 4;
    localparam int EN_CYC      = 31;
    localparam int RCV_CYC     = 40;
    localparam int POLL_MAX_TB = 5;
    localparam int PER_READ    = (AS_CYC + 1) + (EN_CYC + 1) + (RCV_CYC + 1);

    typedef struct {
        logic [7:0] data;
        logic       bf;
        logic [6:0] ac;
        logic       timeout;
        int         lat;
        int         pulses;
        int         start_cyc;
        int         pulse_base;
    } exp_t;

    logic       clk;
    logic       i_rst;
    logic       i_start;
    logic       i_rs;
    logic       i_poll;
    logic       o_busy;
    logic       o_valid;
    logic [7:0] o_data;
    logic       o_busy_flag;
    logic [6:0] o_addr_cnt;
    logic       o_timeout;
    logic [7:0] LCD_DATA_IN;
    logic       LCD_DATA_OE;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;

    exp_t       sb_q[$];
    logic [7:0] bus_q[$];
    logic [7:0] stage_q[$];

    int   n_checks = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   valid_cnt = 0;
    int   en_total = 0;
    int   en_run = 0;
    int   last_en_len = 0;
    int   rw_setup = 0;
    int   viol = 0;
    int   oe_seen = 0;
    logic cur_rs = 1'b0;
    logic exp_bf = 1'b1;
    logic [6:0] exp_ac = '0;

    lcd_reader #(
        .AS_DLY   (5'(AS_CYC)),
        .EN_DLY   (5'(EN_CYC)),
        .RCV_DLY  (6'(RCV_CYC)),
        .POLL_MAX (21'(POLL_MAX_TB))
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_rs        (i_rs),
        .i_poll      (i_poll),
        .o_busy      (o_busy),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_busy_flag (o_busy_flag),
        .o_addr_cnt  (o_addr_cnt),
        .o_timeout   (o_timeout),
        .LCD_DATA_IN (LCD_DATA_IN),
        .LCD_DATA_OE (LCD_DATA_OE),
        .LCD_RS      (LCD_RS),
        .LCD_RW      (LCD_RW),
        .LCD_EN      (LCD_EN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Panel model: presents the next queued byte shortly after each EN rise.
    initial begin
        LCD_DATA_IN = 8'h00;
        forever begin
            @(posedge LCD_EN);
            #2;
            if (bus_q.size() != 0) LCD_DATA_IN = bus_q.pop_front();
        end
    end

    // Bus protocol checker and scoreboard consumer, sampled on the falling edge.
    initial begin : monitor
        logic prev_en, prev_rs, prev_rw;
        exp_t e;
        prev_en = 1'b0;
        prev_rs = 1'b0;
        prev_rw = 1'b0;
        forever begin
            @(negedge clk);
            if (LCD_DATA_OE !== 1'b0) oe_seen++;
            if (i_rst) begin
                en_run   = 0;
                rw_setup = 0;
            end else begin
                if (LCD_EN && !prev_en) begin
                    en_total++;
                    if (rw_setup < AS_CYC) viol++;
                    check("rs_at_en", 32'(LCD_RS), 32'(cur_rs));
                end
                if (LCD_EN && prev_en && (LCD_RS !== prev_rs || LCD_RW !== prev_rw)) viol++;
                if (LCD_EN && !LCD_RW) viol++;
                if (LCD_EN) en_run++;
                else if (prev_en) begin
                    last_en_len = en_run;
                    en_run = 0;
                end
                if (!LCD_RW) rw_setup = 0;
                else if (!LCD_EN) rw_setup++;

                if (o_valid) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_valid", 32'(o_valid), 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("data", 32'(o_data), 32'(e.data));
                        check("busy_flag", 32'(o_busy_flag), 32'(e.bf));
                        check("addr_cnt", 32'(o_addr_cnt), 32'(e.ac));
                        check("timeout", 32'(o_timeout), 32'(e.timeout));
                        check("latency", 32'(cyc - e.start_cyc + 1), 32'(e.lat));
                        check("en_pulses", 32'(en_total - e.pulse_base), 32'(e.pulses));
                        check("busy_at_valid", 32'(o_busy), 32'd1);
                    end
                    valid_cnt++;
                end
            end
            prev_en = LCD_EN;
            prev_rs = LCD_RS;
            prev_rw = LCD_RW;
        end
    end

    // Builds the expected result from stage_q, then runs one transaction.
    task automatic run_read(input logic rs, input logic poll, input bit poke);
        exp_t       e;
        int         n;
        int         base;
        int         k;
        logic [7:0] last;
        n    = 0;
        last = '0;
        do begin
            if (n < stage_q.size()) last = stage_q[n];
            n++;
        end while (poll && !rs && last[7] && n < POLL_MAX_TB);
        if (!rs) begin
            exp_bf = last[7];
            exp_ac = last[6:0];
        end
        e.data    = last;
        e.bf      = exp_bf;
        e.ac      = exp_ac;
        e.timeout = poll && !rs && last[7];
        e.lat     = 2 + PER_READ * n;
        e.pulses  = n;
        bus_q     = stage_q;
        stage_q.delete();
        cur_rs    = rs;

        @(negedge clk);
        e.start_cyc  = cyc;
        e.pulse_base = en_total;
        sb_q.push_back(e);
        base    = valid_cnt;
        i_start = 1'b1;
        i_rs    = rs;
        i_poll  = poll;
        @(negedge clk);
        i_start = 1'b0;
        i_poll  = 1'b0;
        if (poke) begin
            repeat (20) @(negedge clk);
            i_start = 1'b1;
            i_rs    = ~rs;
            i_poll  = 1'b1;
            @(negedge clk);
            i_start = 1'b0;
            i_poll  = 1'b0;
            i_rs    = rs;
        end
        k = 0;
        while (valid_cnt == base && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("valid_seen", 32'(valid_cnt - base), 32'd1);
        @(negedge clk);
        check("busy_fall", 32'(o_busy), 32'd0);
        check("valid_pulse", 32'(o_valid), 32'd0);
        check("rw_release", 32'(LCD_RW), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_data"}, 32'(o_data), 32'd0);
        check({tag, "_bf"}, 32'(o_busy_flag), 32'd1);
        check({tag, "_ac"}, 32'(o_addr_cnt), 32'd0);
        check({tag, "_timeout"}, 32'(o_timeout), 32'd0);
        check({tag, "_en"}, 32'(LCD_EN), 32'd0);
        check({tag, "_rw"}, 32'(LCD_RW), 32'd0);
        check({tag, "_rs"}, 32'(LCD_RS), 32'd0);
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int         base;
        int         k;
        logic [7:0] b;
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_rs    = 1'b0;
        i_poll  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        i_rst = 1'b0;
        repeat (2) @(negedge clk);

        // Plain status read.
        stage_q.push_back(8'h45);
        run_read(1'b0, 1'b0, 1'b0);
        check("en_high_len", 32'(last_en_len), 32'(EN_CYC + 1));

        // Data read leaves BF/AC alone.
        stage_q.push_back(8'h41);
        run_read(1'b1, 1'b0, 1'b0);

        // Poll: busy for three reads, then ready.
        stage_q.push_back(8'h85);
        stage_q.push_back(8'h86);
        stage_q.push_back(8'h87);
        stage_q.push_back(8'h12);
        run_read(1'b0, 1'b1, 1'b0);

        // Poll with BF stuck high runs into the timeout.
        for (int i = 0; i < 6; i++) stage_q.push_back(8'h9a);
        run_read(1'b0, 1'b1, 1'b0);

        // i_poll is ignored on a data read; timeout clears on the new start.
        stage_q.push_back(8'hc3);
        stage_q.push_back(8'h01);
        run_read(1'b1, 1'b1, 1'b0);

        // A second i_start while busy must not queue another cycle.
        stage_q.push_back(8'h33);
        stage_q.push_back(8'h44);
        run_read(1'b0, 1'b0, 1'b1);
        base = en_total;
        repeat (100) @(negedge clk);
        check("ignored_start_pulses", 32'(en_total - base), 32'd0);
        check("ignored_start_busy", 32'(o_busy), 32'd0);

        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(0, 127));
            stage_q.push_back(b);
            run_read(1'b0, 1'b0, 1'b0);
        end

        // Reset in the middle of the EN-high phase.
        bus_q.delete();
        bus_q.push_back(8'h7e);
        cur_rs = 1'b0;
        @(negedge clk);
        i_start = 1'b1;
        i_rs    = 1'b0;
        @(negedge clk);
        i_start = 1'b0;
        k = 0;
        while (!LCD_EN && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("enhi_reached", 32'(LCD_EN), 32'd1);
        repeat (5) @(negedge clk);
        i_rst = 1'b1;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        i_rst  = 1'b0;
        exp_bf = 1'b1;
        exp_ac = '0;
        repeat (2) @(negedge clk);

        stage_q.push_back(8'h2a);
        run_read(1'b0, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        check("bus_protocol", 32'(viol), 32'd0);
        check("oe_never_high", 32'(oe_seen), 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
